sort_packet_sequencer: RTL and testbench

Top-level control sequencer for the packet sort path. It accepts one Avalon-ST-style packet (sop/eop) into an external single-port-write/single-port-read buffer RAM and launches the sort core. It waits for the core to finish, then drains the buffer to the source interface with sop/eop framing and src_ready backpressure. Handles one packet at a time; the sink is held off while sorting and draining.

---
 rtl/sort_packet_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_sort_packet_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_packet_sequencer.sv
// sort_packet_sequencer
// Control sequencer for the packet sort path. It takes one sop/eop-framed
// packet into an external buffer RAM, launches the sort core, waits for it
// to finish, then drains the buffer to the source interface with sop/eop
// framing under src_ready backpressure. One packet is handled at a time.
//
// Ports:
//   snk_clock, snk_reset          clock, async active-high reset
//   snk_valid/sop/eop, snk_ready  sink handshake (data goes straight to RAM)
//   ram_we, ram_waddr             buffer write port
//   ram_re, ram_raddr             buffer read port (q valid 1 cycle after re)
//   sort_start, sort_len          sort core launch pulse and word count
//   sort_done                     sort core completion (sampled in SORT)
//   src_valid/sop/eop, src_ready  source handshake (data is RAM q)
//   busy                          sequencer not idle
//   err_overflow                  one-cycle pulse: packet longer than DEPTH
module sort_packet_sequencer #(
  parameter int AWIDTH = 4
) (
  input  logic              snk_clock,
  input  logic              snk_reset,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_raddr,
  output logic              sort_start,
  output logic [AWIDTH:0]   sort_len,
  input  logic              sort_done,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  input  logic              src_ready,
  output logic              busy,
  output logic              err_overflow
);

  localparam logic [AWIDTH-1:0] PTR_LAST = {AWIDTH{1'b1}};
  localparam logic [AWIDTH:0]   LEN_MAX  = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DROP  = 3'd2,
    SORT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   sort_len_q, sort_len_d;
  logic              sort_start_q, sort_start_d;
  logic              err_overflow_q, err_overflow_d;
  logic              src_valid_q, src_valid_d;
  logic              src_sop_q, src_sop_d;
  logic              src_eop_q, src_eop_d;
  logic              snk_ready_s;
  logic              take_s;
  logic              ram_we_s;
  logic              ram_re_s;

  // Next-state, pointer and source-framing logic.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    sort_len_d     = sort_len_q;
    sort_start_d   = 1'b0;
    err_overflow_d = 1'b0;
    src_valid_d    = 1'b0;
    src_sop_d      = 1'b0;
    src_eop_d      = 1'b0;
    ram_we_s       = 1'b0;
    ram_re_s       = 1'b0;
    snk_ready_s    = 1'b0;

    case (state_q)
      IDLE, FILL, DROP: snk_ready_s = 1'b1;
      default:          snk_ready_s = 1'b0;
    endcase
    take_s = snk_valid && snk_ready_s;

    case (state_q)
      IDLE: begin
        // Beats without sop are swallowed here so stray data never reaches RAM.
        if (take_s && snk_sop) begin
          ram_we_s = 1'b1;
          wr_ptr_d = {{(AWIDTH-1){1'b0}}, 1'b1};
          if (snk_eop) begin
            sort_len_d   = {{AWIDTH{1'b0}}, 1'b1};
            sort_start_d = 1'b1;
            state_d      = SORT;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (take_s) begin
          ram_we_s = 1'b1;
          if (snk_eop) begin
            sort_len_d   = {1'b0, wr_ptr_q} + {{AWIDTH{1'b0}}, 1'b1};
            sort_start_d = 1'b1;
            state_d      = SORT;
          end else if (wr_ptr_q == PTR_LAST) begin
            // Buffer full and packet continues: keep what fits, discard the tail.
            sort_len_d     = LEN_MAX;
            err_overflow_d = 1'b1;
            state_d        = DROP;
          end else begin
            wr_ptr_d = wr_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      DROP: begin
        if (take_s && snk_eop) begin
          sort_start_d = 1'b1;
          state_d      = SORT;
        end
      end
      SORT: begin
        // sort_start_q marks the first SORT cycle, where sort_done is ignored.
        if (!sort_start_q && sort_done) begin
          rd_ptr_d = {(AWIDTH+1){1'b0}};
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        ram_re_s = (rd_ptr_q < sort_len_q) && (!src_valid_q || src_ready);
        if (ram_re_s) begin
          rd_ptr_d    = rd_ptr_q + {{AWIDTH{1'b0}}, 1'b1};
          src_valid_d = 1'b1;
          src_sop_d   = (rd_ptr_q == {(AWIDTH+1){1'b0}});
          src_eop_d   = (rd_ptr_q == (sort_len_q - {{AWIDTH{1'b0}}, 1'b1}));
        end else if (src_valid_q && !src_ready) begin
          src_valid_d = 1'b1;
          src_sop_d   = src_sop_q;
          src_eop_d   = src_eop_q;
        end else begin
          src_valid_d = 1'b0;
        end
        if (src_valid_q && src_ready && src_eop_q) begin
          src_valid_d = 1'b0;
          src_sop_d   = 1'b0;
          src_eop_d   = 1'b0;
          wr_ptr_d    = {AWIDTH{1'b0}};
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge snk_clock or posedge snk_reset) begin
    if (snk_reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= {AWIDTH{1'b0}};
      rd_ptr_q       <= {(AWIDTH+1){1'b0}};
      sort_len_q     <= {(AWIDTH+1){1'b0}};
      sort_start_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      src_valid_q    <= 1'b0;
      src_sop_q      <= 1'b0;
      src_eop_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      sort_len_q     <= sort_len_d;
      sort_start_q   <= sort_start_d;
      err_overflow_q <= err_overflow_d;
      src_valid_q    <= src_valid_d;
      src_sop_q      <= src_sop_d;
      src_eop_q      <= src_eop_d;
    end
  end

  // RAM strobes are combinational because write data rides the sink bus in
  // the same cycle; the write is gated during reset since IDLE accepts sop.
  assign snk_ready    = snk_ready_s;
  assign ram_we       = ram_we_s && !snk_reset;
  assign ram_waddr    = wr_ptr_q;
  assign ram_re       = ram_re_s;
  assign ram_raddr    = rd_ptr_q[AWIDTH-1:0];
  assign sort_start   = sort_start_q;
  assign sort_len     = sort_len_q;
  assign src_valid    = src_valid_q;
  assign src_sop      = src_sop_q;
  assign src_eop      = src_eop_q;
  assign busy         = (state_q != IDLE);
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_sort_packet_sequencer.sv
module tb_sort_packet_sequencer;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
  logic [7:0]    snk_data = 8'd0;
  logic          snk_ready;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic          sort_start, sort_done = 1'b0;
  logic [AW:0]   sort_len;
  logic          src_valid, src_sop, src_eop, src_ready;
  logic          busy, err_overflow;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;
  logic [AW:0] got_len;

  sort_packet_sequencer #(.AWIDTH(AW)) dut (
    .snk_clock(clk), .snk_reset(rst),
    .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_ready(snk_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .sort_start(sort_start), .sort_len(sort_len), .sort_done(sort_done),
    .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop), .src_ready(src_ready),
    .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Buffer RAM model
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ram_q = 8'd0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= snk_data;
    if (ram_re) ram_q <= mem[ram_raddr];
  end

  // src_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = never ready
  int phase = 0;
  always @(negedge clk) begin
    if (rdy_mode == 0) src_ready = 1'b1;
    else if (rdy_mode == 1) begin
      src_ready = (phase == 0);
      phase = (phase + 1) % 3;
    end else src_ready = 1'b0;
  end

  // Event monitors (append-only logs)
  int cyc = 0;
  int wr_log[$];
  int rd_log[$];
  int rd_cyc[$];
  int x_data[$];
  int x_sop[$];
  int x_eop[$];
  int start_cnt = 0, ovf_cnt = 0, stall_bad = 0, re_bad = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic prev_sop = 1'b0, prev_eop = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) prev_stall <= 1'b0;
    else begin
      if (ram_we) wr_log.push_back(int'(ram_waddr));
      if (ram_re) begin rd_log.push_back(int'(ram_raddr)); rd_cyc.push_back(cyc); end
      if (sort_start) start_cnt <= start_cnt + 1;
      if (err_overflow) ovf_cnt <= ovf_cnt + 1;
      if (src_valid && src_ready) begin
        x_data.push_back(int'(ram_q)); x_sop.push_back(int'(src_sop)); x_eop.push_back(int'(src_eop));
      end
      if (ram_re && src_valid && !src_ready) re_bad <= re_bad + 1;
      if (prev_stall && (!src_valid || ram_q !== prev_data || src_sop !== prev_sop || src_eop !== prev_eop))
        stall_bad <= stall_bad + 1;
      prev_stall <= src_valid && !src_ready;
      prev_data  <= ram_q;
      prev_sop   <= src_sop;
      prev_eop   <= src_eop;
    end
  end

  task automatic send_pkt(input int n, input int d0, input int done_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      snk_valid = 1'b1; snk_sop = (i == 0); snk_eop = (i == n - 1);
      snk_data = 8'(d0 + i); sort_done = (i == done_idx);
    end
    @(negedge clk);
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; sort_done = 1'b0;
  endtask

  // Wait for sort_start (already at a negedge), record sort_len, pulse sort_done later
  task automatic start_sort(input int delay);
    bit found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (sort_start) found = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL sort_start_seen: got 0 want 1"); end
    got_len = sort_len;
    n_vec++;
    if (snk_ready !== 1'b0) begin n_err++; $display("FAIL snk_ready_in_sort: got %b want 0", snk_ready); end
    repeat (delay) @(negedge clk);
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL busy_timeout: busy got 1 want 0"); end
  endtask

  // Checks write addresses, transfers and framing since the given log bases
  task automatic check_pkt(input string nm, input int wb, input int xb, input int nw, input int nx, input int d0);
    n_vec++;
    if (wr_log.size() - wb != nw) begin n_err++; $display("FAIL %s wr_count: got %0d want %0d", nm, wr_log.size() - wb, nw); end
    for (int i = 0; i < nw && wb + i < wr_log.size(); i++) begin
      n_vec++;
      if (wr_log[wb + i] != i) begin n_err++; $display("FAIL %s wr_addr[%0d]: got %0d want %0d", nm, i, wr_log[wb + i], i); end
    end
    n_vec++;
    if (x_data.size() - xb != nx) begin n_err++; $display("FAIL %s xfer_count: got %0d want %0d", nm, x_data.size() - xb, nx); end
    for (int i = 0; i < nx && xb + i < x_data.size(); i++) begin
      n_vec++;
      if (x_data[xb + i] != ((d0 + i) & 255) || x_sop[xb + i] != int'(i == 0) || x_eop[xb + i] != int'(i == nx - 1)) begin
        n_err++;
        $display("FAIL %s xfer[%0d]: got data=%0d sop=%0d eop=%0d want data=%0d sop=%0d eop=%0d", nm, i,
                 x_data[xb + i], x_sop[xb + i], x_eop[xb + i], (d0 + i) & 255, int'(i == 0), int'(i == nx - 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_vec++;
    if ({snk_ready, busy, src_valid, sort_start, err_overflow, ram_we, ram_re} !== 7'b1000000 || sort_len !== 4'd0) begin
      n_err++; $display("FAIL reset_outputs: got rdy=%b busy=%b sv=%b ss=%b ovf=%b we=%b re=%b len=%0d want 1,0,0,0,0,0,0,0",
                        snk_ready, busy, src_valid, sort_start, err_overflow, ram_we, ram_re, sort_len);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int wb = wr_log.size(), xb = x_data.size(), rb = rd_log.size(), sb = start_cnt, ob = ovf_cnt;
    rdy_mode = 0;
    send_pkt(4, 8'h10, -1);
    start_sort(5);
    wait_idle();
    check_pkt("basic", wb, xb, 4, 4, 8'h10);
    n_vec++;
    if (got_len !== 4'd4) begin n_err++; $display("FAIL basic sort_len: got %0d want 4", got_len); end
    n_vec++;
    if (start_cnt - sb != 1) begin n_err++; $display("FAIL basic start_pulse: got %0d want 1", start_cnt - sb); end
    n_vec++;
    if (ovf_cnt != ob) begin n_err++; $display("FAIL basic overflow: got %0d want 0", ovf_cnt - ob); end
    n_vec++;
    if (rd_log.size() - rb != 4) begin n_err++; $display("FAIL basic rd_count: got %0d want 4", rd_log.size() - rb); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (rd_log[rb + i] != i || rd_cyc[rb + i] != rd_cyc[rb] + i) begin
          n_err++; $display("FAIL basic rd[%0d]: got addr=%0d dcyc=%0d want addr=%0d dcyc=%0d", i, rd_log[rb + i], rd_cyc[rb + i] - rd_cyc[rb], i, i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int wb = wr_log.size(), xb = x_data.size(), sbad = stall_bad, rbad = re_bad;
    rdy_mode = 1;
    send_pkt(4, 8'h20, -1);
    start_sort(5);
    wait_idle();
    rdy_mode = 0;
    check_pkt("bp", wb, xb, 4, 4, 8'h20);
    n_vec++;
    if (stall_bad != sbad) begin n_err++; $display("FAIL bp stall_stable: got %0d changes want 0", stall_bad - sbad); end
    n_vec++;
    if (re_bad != rbad) begin n_err++; $display("FAIL bp re_while_stalled: got %0d want 0", re_bad - rbad); end
  endtask

  task automatic test_single();
    int wb = wr_log.size(), xb = x_data.size();
    send_pkt(1, 8'h33, -1);
    start_sort(2);
    wait_idle();
    check_pkt("single", wb, xb, 1, 1, 8'h33);
    n_vec++;
    if (got_len !== 4'd1) begin n_err++; $display("FAIL single sort_len: got %0d want 1", got_len); end
  endtask

  task automatic test_overflow();
    int wb = wr_log.size(), xb = x_data.size(), ob = ovf_cnt;
    send_pkt(11, 8'h40, -1);
    start_sort(3);
    wait_idle();
    check_pkt("ovf11", wb, xb, 8, 8, 8'h40);
    n_vec++;
    if (got_len !== 4'd8) begin n_err++; $display("FAIL ovf11 sort_len: got %0d want 8", got_len); end
    n_vec++;
    if (ovf_cnt - ob != 1) begin n_err++; $display("FAIL ovf11 err_pulses: got %0d want 1", ovf_cnt - ob); end
    wb = wr_log.size(); xb = x_data.size(); ob = ovf_cnt;
    send_pkt(8, 8'h60, -1);
    start_sort(3);
    wait_idle();
    check_pkt("full8", wb, xb, 8, 8, 8'h60);
    n_vec++;
    if (got_len !== 4'd8) begin n_err++; $display("FAIL full8 sort_len: got %0d want 8", got_len); end
    n_vec++;
    if (ovf_cnt != ob) begin n_err++; $display("FAIL full8 err_pulses: got %0d want 0", ovf_cnt - ob); end
  endtask

  task automatic test_stray();
    int wb = wr_log.size(), xb = x_data.size();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      snk_valid = 1'b1; snk_sop = 1'b0; snk_eop = (i == 1); snk_data = 8'hEE;
    end
    @(negedge clk);
    snk_valid = 1'b0; snk_eop = 1'b0;
    n_vec++;
    if (wr_log.size() != wb || busy !== 1'b0) begin
      n_err++; $display("FAIL stray: got writes=%0d busy=%b want 0,0", wr_log.size() - wb, busy);
    end
    send_pkt(3, 8'h80, 1);
    start_sort(2);
    wait_idle();
    check_pkt("spurious_done", wb, xb, 3, 3, 8'h80);
    n_vec++;
    if (got_len !== 4'd3) begin n_err++; $display("FAIL spurious_done sort_len: got %0d want 3", got_len); end
  endtask

  task automatic test_reset_drain();
    int wb, xb;
    bit seen = 1'b0;
    rdy_mode = 2;
    send_pkt(3, 8'h90, -1);
    start_sort(1);
    for (int k = 0; k < 20 && !seen; k++) begin
      if (src_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL rst_drain src_valid_seen: got 0 want 1"); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({snk_ready, busy, src_valid, src_sop, src_eop, sort_start, ram_re, ram_we} !== 8'b10000000 || sort_len !== 4'd0) begin
      n_err++; $display("FAIL rst_drain outputs: got rdy=%b busy=%b sv=%b sop=%b eop=%b ss=%b re=%b we=%b len=%0d want 1,0,0,0,0,0,0,0,0",
                        snk_ready, busy, src_valid, src_sop, src_eop, sort_start, ram_re, ram_we, sort_len);
    end
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    wb = wr_log.size(); xb = x_data.size();
    send_pkt(2, 8'hA0, -1);
    start_sort(2);
    wait_idle();
    check_pkt("after_rst", wb, xb, 2, 2, 8'hA0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_overflow();
    test_stray();
    test_reset_drain();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
